// File: rtl/attn_pkg.sv
// Shared types for the attention-head matrix readers: FSM state encoding,
// output FIFO sizing and the per-element tag carried alongside read data.
package attn_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2
  } rd_state_e;

  localparam int FIFO_DEPTH = 2;
  localparam int FIFO_PTR_W = $clog2(FIFO_DEPTH);

  // Index fields are sized for matrix dimensions up to IDX_W bits.
  localparam int IDX_W = 16;

  typedef struct packed {
    logic [IDX_W-1:0] pixel;
    logic [IDX_W-1:0] slice;
    logic             row_last;
    logic             mat_last;
  } elem_tag_t;

endpackage

// File: rtl/matrix_reader_fifo.sv
// Two-entry output FIFO holding read data plus its element tag. Occupancy is
// bounded by the reader's credit counter, so no full flag is exposed.
module matrix_reader_fifo
  import attn_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  elem_tag_t         push_tag,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic              valid,
  output elem_tag_t         head_tag,
  output logic [DATA_W-1:0] head_data
);

  elem_tag_t               tag_mem  [FIFO_DEPTH];
  logic [DATA_W-1:0]       data_mem [FIFO_DEPTH];
  logic [FIFO_PTR_W-1:0]   wr_ptr;
  logic [FIFO_PTR_W-1:0]   rd_ptr;
  logic [FIFO_PTR_W:0]     count;
  logic                    do_pop;

  assign valid  = (count != '0);
  assign do_pop = pop && valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: storage is reset too, so the stream outputs read as zero after reset.
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        tag_mem[i]  <= '0;
        data_mem[i] <= '0;
      end
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        tag_mem[wr_ptr]  <= push_tag;
        data_mem[wr_ptr] <= push_data;
        wr_ptr           <= wr_ptr + FIFO_PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + FIFO_PTR_W'(1);
      end
      case ({push, do_pop})
        2'b10:   count <= count + (FIFO_PTR_W+1)'(1);
        2'b01:   count <= count - (FIFO_PTR_W+1)'(1);
        default: ;
      endcase
    end
  end

  assign head_tag  = tag_mem[rd_ptr];
  assign head_data = data_mem[rd_ptr];

endmodule

// File: rtl/matrix_reader.sv
// Streams a WIDTH x HEIGHT matrix out of a 1-cycle-latency memory with tags.
// Define MATRIX_READER_TRANSPOSE_EN for column-major traversal.
module matrix_reader
  import attn_pkg::*;
#(
  parameter int MATRIXSIZE_W = 16,
  parameter int ADDR_W       = 16,
  parameter int DATA_W       = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [MATRIXSIZE_W-1:0] WIDTH,
  input  logic [MATRIXSIZE_W-1:0] HEIGHT,
  input  logic [ADDR_W-1:0]       base_addr,
  output logic                    busy,
  output logic                    done,
  output logic                    mem_rd_en,
  output logic [ADDR_W-1:0]       mem_addr,
  input  logic [DATA_W-1:0]       mem_rd_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DATA_W-1:0]       out_data,
  output logic [MATRIXSIZE_W-1:0] pixel_idx,
  output logic [MATRIXSIZE_W-1:0] slice_idx,
  output logic                    out_row_last,
  output logic                    out_mat_last
);

  rd_state_e               state_q;
  logic [MATRIXSIZE_W-1:0] width_q;
  logic [MATRIXSIZE_W-1:0] height_q;
  logic [MATRIXSIZE_W-1:0] pix_q;
  logic [MATRIXSIZE_W-1:0] slc_q;
  logic [ADDR_W-1:0]       addr_q;
  logic [1:0]              credits_q;
  logic                    rd_pending_q;
  logic                    done_q;
  elem_tag_t               issue_tag;
  elem_tag_t               tag_q;
  elem_tag_t               head_tag;
  logic [DATA_W-1:0]       head_data;
  logic                    fifo_valid;
  logic                    pop;
  logic                    issue;
  logic                    pix_last;
  logic                    slc_last;
  logic                    row_last;
  logic                    mat_last;
`ifdef MATRIX_READER_TRANSPOSE_EN
  logic [ADDR_W-1:0]       base_q;
`endif

  assign pix_last = (pix_q == width_q - MATRIXSIZE_W'(1));
  assign slc_last = (slc_q == height_q - MATRIXSIZE_W'(1));
  assign mat_last = pix_last && slc_last;
`ifdef MATRIX_READER_TRANSPOSE_EN
  assign row_last = slc_last;
`else
  assign row_last = pix_last;
`endif

  // A full credit count may still issue when a pop frees a slot this cycle.
  assign pop   = fifo_valid && out_ready;
  assign issue = (state_q == ST_ISSUE) && ((credits_q < 2'd2) || pop);

  always_comb begin
    // NOTE: default the whole struct first so no field can infer a latch.
    issue_tag          = '0;
    issue_tag.pixel    = IDX_W'(pix_q);
    issue_tag.slice    = IDX_W'(slc_q);
    issue_tag.row_last = row_last;
    issue_tag.mat_last = mat_last;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      width_q  <= '0;
      height_q <= '0;
      pix_q    <= '0;
      slc_q    <= '0;
      addr_q   <= '0;
      done_q   <= 1'b0;
`ifdef MATRIX_READER_TRANSPOSE_EN
      base_q   <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            if ((WIDTH != '0) && (HEIGHT != '0)) begin
              width_q  <= WIDTH;
              height_q <= HEIGHT;
              pix_q    <= '0;
              slc_q    <= '0;
              addr_q   <= base_addr;
              state_q  <= ST_ISSUE;
`ifdef MATRIX_READER_TRANSPOSE_EN
              base_q   <= base_addr;
`endif
            end else begin
              done_q <= 1'b1;
            end
          end
        end
        ST_ISSUE: begin
          if (issue) begin
`ifdef MATRIX_READER_TRANSPOSE_EN
            // Column end restarts at the top of the next column.
            if (slc_last) begin
              slc_q  <= '0;
              pix_q  <= pix_q + MATRIXSIZE_W'(1);
              addr_q <= base_q + ADDR_W'(pix_q) + ADDR_W'(1);
            end else begin
              slc_q  <= slc_q + MATRIXSIZE_W'(1);
              addr_q <= addr_q + ADDR_W'(width_q);
            end
`else
            addr_q <= addr_q + ADDR_W'(1);
            if (pix_last) begin
              pix_q <= '0;
              slc_q <= slc_q + MATRIXSIZE_W'(1);
            end else begin
              pix_q <= pix_q + MATRIXSIZE_W'(1);
            end
`endif
            if (mat_last) begin
              state_q <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          if (pop && head_tag.mat_last) begin
            state_q <= ST_IDLE;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Credits count reads in flight plus elements held in the FIFO.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      credits_q    <= '0;
      rd_pending_q <= 1'b0;
      tag_q        <= '0;
    end else begin
      case ({issue, pop})
        2'b10:   credits_q <= credits_q + 2'd1;
        2'b01:   credits_q <= credits_q - 2'd1;
        default: ;
      endcase
      rd_pending_q <= issue;
      if (issue) begin
        tag_q <= issue_tag;
      end
    end
  end

  matrix_reader_fifo #(
    .DATA_W (DATA_W)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (rd_pending_q),
    .push_tag  (tag_q),
    .push_data (mem_rd_data),
    .pop       (pop),
    .valid     (fifo_valid),
    .head_tag  (head_tag),
    .head_data (head_data)
  );

  assign busy         = (state_q != ST_IDLE);
  assign done         = done_q;
  assign mem_rd_en    = issue;
  assign mem_addr     = addr_q;
  assign out_valid    = fifo_valid;
  assign out_data     = head_data;
  assign pixel_idx    = MATRIXSIZE_W'(head_tag.pixel);
  assign slice_idx    = MATRIXSIZE_W'(head_tag.slice);
  assign out_row_last = head_tag.row_last;
  assign out_mat_last = head_tag.mat_last;

endmodule
